dataram: RTL and testbench

AXI4-Lite responder that implements the processor's data RAM. It terminates the data-region port produced by the memory router and accepts word-wide reads and byte-strobed writes. Read and write channels run independently. Each accepted transaction gets exactly one response beat.

---
 rtl/axi4.sv | 6 +
 rtl/dataram_pkg.sv | 9 +
 rtl/rv32.sv | 5 +
 rtl/axi.sv | 33 +++
 rtl/dataram_mem.sv | 26 ++
 rtl/dataram.sv | 174 +++++++++++++++++
 tb/tb_dataram.sv | 320 ++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/axi4.sv
// axi4: AXI response encodings.
package axi4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/dataram_pkg.sv
// dataram_pkg: geometry helpers for the data RAM.
package dataram_pkg;
  localparam int unsigned WORD_BYTES = 4;

  // Word-index width for a byte capacity; never narrower than one bit.
  function automatic int idx_width(input int unsigned size);
    return (size > WORD_BYTES) ? $clog2(size) - 2 : 1;
  endfunction
endpackage

// File: rtl/rv32.sv
// rv32: processor memory-map constants shared across the SoC.
package rv32;
  localparam logic [31:0] DATA_BASE = 32'h1000_0000;
  localparam int unsigned DATA_SIZE = 32'h0000_1000;
endpackage

// File: rtl/axi.sv
// axi: AXI4-Lite bundle with 32-bit address and data.
interface axi;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dataram_mem.sv
// dataram_mem: single-clock RAM, byte-enabled write port and read-first registered read port.
module dataram_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int          IW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Read-first: a read and write of the same word on one edge returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dataram.sv
// dataram: AXI4-Lite data RAM responder with independent write and read FSMs.
// Define DATARAM_RANGE_CHECK_EN to answer out-of-window accesses with SLVERR.
module dataram #(
  parameter logic [31:0] BASE = rv32::DATA_BASE,
  parameter int unsigned SIZE = rv32::DATA_SIZE
) (
  input logic clk,
  input logic reset,
  axi.slave   bus
);
  import dataram_pkg::*;

  localparam int unsigned DEPTH = SIZE / WORD_BYTES;
  localparam int          IW    = idx_width(SIZE);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic [31:0]   aw_off, ar_off;
  logic [IW-1:0] aw_idx, ar_idx;
  logic          aw_ok, ar_ok;
  logic          aw_hs, w_hs, ar_hs;
  logic [IW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          wok_q, rok_q;
  logic          commit, c_ok;
  logic [IW-1:0] c_idx;
  logic [31:0]   c_data;
  logic [3:0]    c_strb;
  logic [31:0]   mem_rdata;
  logic          unused_bits;

  assign aw_off = bus.awaddr - BASE;
  assign ar_off = bus.araddr - BASE;
  assign aw_idx = aw_off[IW+1:2];
  assign ar_idx = ar_off[IW+1:2];

`ifdef DATARAM_RANGE_CHECK_EN
  assign aw_ok = aw_off < SIZE;
  assign ar_ok = ar_off < SIZE;
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  assign unused_bits = ^{bus.awprot, bus.arprot, aw_off, ar_off};

  // Ready/valid decode straight from state so no input reaches them combinationally.
  assign bus.awready = (wstate == W_IDLE) || (wstate == W_DATA);
  assign bus.wready  = (wstate == W_IDLE) || (wstate == W_ADDR);
  assign bus.bvalid  = (wstate == W_RESP);
  assign bus.arready = (rstate == R_IDLE);
  assign bus.rvalid  = (rstate == R_RESP);

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
    end
  end

  // Commit sources come from the live channel when it completes this cycle, else the held copy.
  always_comb begin
    wstate_nxt = wstate;
    commit     = 1'b0;
    c_idx      = waddr_q;
    c_data     = wdata_q;
    c_strb     = wstrb_q;
    c_ok       = wok_q;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          c_idx      = aw_idx;
          c_ok       = aw_ok;
          c_data     = bus.wdata;
          c_strb     = bus.wstrb;
          wstate_nxt = W_RESP;
        end else if (aw_hs) begin
          wstate_nxt = W_ADDR;
        end else if (w_hs) begin
          wstate_nxt = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          commit     = 1'b1;
          c_data     = bus.wdata;
          c_strb     = bus.wstrb;
          wstate_nxt = W_RESP;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          commit     = 1'b1;
          c_idx      = aw_idx;
          c_ok       = aw_ok;
          wstate_nxt = W_RESP;
        end
      end
      default: begin
        if (bus.bready) wstate_nxt = W_IDLE;
      end
    endcase
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
      default: if (bus.rready) rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      waddr_q <= aw_idx;
      wok_q   <= aw_ok;
    end
    if (w_hs) begin
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end
    if (ar_hs) rok_q <= ar_ok;
  end

`ifdef DATARAM_RANGE_CHECK_EN
  logic [1:0] bresp_q, rresp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bresp_q <= axi4::OKAY;
      rresp_q <= axi4::OKAY;
    end else begin
      if (commit) bresp_q <= c_ok ? axi4::OKAY : axi4::SLVERR;
      if (ar_hs)  rresp_q <= ar_ok ? axi4::OKAY : axi4::SLVERR;
    end
  end

  assign bus.bresp = bresp_q;
  assign bus.rresp = rresp_q;
`else
  assign bus.bresp = axi4::OKAY;
  assign bus.rresp = axi4::OKAY;
`endif

  // The RAM output register is not reset, so rdata is gated to zero outside a valid R beat.
  assign bus.rdata = ((rstate == R_RESP) && rok_q) ? mem_rdata : 32'h0;

  dataram_mem #(
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_mem (
    .clk  (clk),
    .we   (commit && c_ok),
    .waddr(c_idx),
    .wdata(c_data),
    .wbe  (c_strb),
    .re   (ar_hs),
    .raddr(ar_idx),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_dataram.sv
// tb_dataram: table-driven, directed and randomized checks of dataram against a word-array model.
module tb_dataram;
  localparam logic [31:0] BASE  = rv32::DATA_BASE;
  localparam int unsigned SIZE  = rv32::DATA_SIZE;
  localparam int unsigned DEPTH = SIZE / 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  logic [31:0] mdl [DEPTH];

  axi bus_if ();

  dataram dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic in_window(input logic [31:0] addr);
    return (addr - BASE) < SIZE;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'(((addr - BASE) >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bdelay, output logic [1:0] resp);
    int   aw_start, w_start, cyc;
    logic aw_done, w_done, aw_hs, w_hs;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done  = 1'b0;
    w_done   = 1'b0;
    cyc      = 0;
    bus_if.awaddr = addr;
    bus_if.wdata  = data;
    bus_if.wstrb  = strb;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        timeout("write_handshake");
        break;
      end
      bus_if.awvalid = !aw_done && (cyc >= aw_start);
      bus_if.wvalid  = !w_done && (cyc >= w_start);
      if (w_done && !aw_done) chk("wready_low_while_waiting_aw", 32'(bus_if.wready), 32'd0);
      if (aw_done && !w_done) chk("awready_low_while_waiting_w", 32'(bus_if.awready), 32'd0);
      aw_hs = bus_if.awvalid && bus_if.awready;
      w_hs  = bus_if.wvalid && bus_if.wready;
      cyc1();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
    end
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    chk("bvalid_after_commit", 32'(bus_if.bvalid), 32'd1);
    for (int i = 0; i < bdelay; i++) cyc1();
    resp = bus_if.bresp;
    bus_if.bready = 1'b1;
    cyc1();
    bus_if.bready = 1'b0;
    chk("b_single_beat", 32'(bus_if.bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int   cyc;
    logic hs;
    cyc = 0;
    hs  = 1'b0;
    bus_if.araddr  = addr;
    bus_if.arvalid = 1'b1;
    while (!hs) begin
      if (cyc > 40) begin
        timeout("read_handshake");
        break;
      end
      hs = bus_if.arready;
      cyc1();
      cyc++;
    end
    bus_if.arvalid = 1'b0;
    chk("rvalid_after_ar", 32'(bus_if.rvalid), 32'd1);
    data = bus_if.rdata;
    resp = bus_if.rresp;
    bus_if.rready = 1'b1;
    cyc1();
    bus_if.rready = 1'b0;
    chk("r_single_beat", 32'(bus_if.rvalid), 32'd0);
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
`ifdef DATARAM_RANGE_CHECK_EN
    return in_window(addr) ? axi4::OKAY : axi4::SLVERR;
`else
    return in_window(addr) ? axi4::OKAY : axi4::OKAY;
`endif
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int i;
    i = widx(addr);
    if (exp_resp(addr) == axi4::OKAY) mdl[i] = (mdl[i] & ~lane_mask(strb)) | (data & lane_mask(strb));
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int lead, input int bdelay);
    logic [1:0] resp;
    do_write(addr, data, strb, lead, bdelay, resp);
    model_write(addr, data, strb);
    chk("bresp", 32'(resp), 32'(exp_resp(addr)));
  endtask

  task automatic rd(input logic [31:0] addr);
    logic [31:0] data;
    logic [1:0]  resp;
    do_read(addr, data, resp);
    chk("rresp", 32'(resp), 32'(exp_resp(addr)));
    chk("rdata", data, (exp_resp(addr) == axi4::OKAY) ? mdl[widx(addr)] : 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    n_chk  = 0;
    n_fail = 0;
    clk    = 1'b0;
    reset  = 1'b1;
    bus_if.awaddr  = '0;
    bus_if.awprot  = '0;
    bus_if.awvalid = 1'b0;
    bus_if.wdata   = '0;
    bus_if.wstrb   = '0;
    bus_if.wvalid  = 1'b0;
    bus_if.bready  = 1'b0;
    bus_if.araddr  = '0;
    bus_if.arprot  = '0;
    bus_if.arvalid = 1'b0;
    bus_if.rready  = 1'b0;

    vt[0] = '{32'h40, 32'h11223344, 4'hF, 0,  32'h11223344};
    vt[1] = '{32'h40, 32'hAABBCCDD, 4'h3, 2,  32'h1122CCDD};
    vt[2] = '{32'h40, 32'h99887766, 4'h8, -1, 32'h9922CCDD};
    vt[3] = '{32'h40, 32'hFFFFFFFF, 4'h0, 0,  32'h9922CCDD};
    vt[4] = '{32'h44, 32'h01020304, 4'hF, 3,  32'h01020304};
    vt[5] = '{32'h47, 32'h0A0B0C0D, 4'h4, -2, 32'h010B0304};
    vt[6] = '{32'hFFC, 32'h5A5A5A5A, 4'hF, 0, 32'h5A5A5A5A};

    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(bus_if.awready), 32'd1);
    chk("rst_wready",  32'(bus_if.wready),  32'd1);
    chk("rst_arready", 32'(bus_if.arready), 32'd1);
    chk("rst_bvalid",  32'(bus_if.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus_if.rvalid),  32'd0);
    chk("rst_resps",   32'({bus_if.bresp, bus_if.rresp}), 32'd0);
    chk("rst_rdata",   bus_if.rdata, 32'h0);
    reset = 1'b0;
    cyc1();

    wr(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    rd(BASE + 32'h10);

    wr(BASE + 32'h30, 32'h11223344, 4'hF, 0, 0);
    wr(BASE + 32'h30, 32'h000000AA, 4'h1, 3, 0);
    cyc1();
    chk("no_extra_b_beat", 32'(bus_if.bvalid), 32'd0);
    do_read(BASE + 32'h30, d, r);
    chk("strobe_merge", d, 32'h112233AA);

    for (int i = 0; i < 7; i++) begin
      wr(BASE + vt[i].off, vt[i].data, vt[i].strb, vt[i].lead, i % 3);
      do_read(BASE + vt[i].off, d, r);
      chk("table_rdata", d, vt[i].exp);
    end

    // B stalled five cycles; a read is serviced during the stall.
    bus_if.awaddr  = BASE + 32'h50;
    bus_if.wdata   = 32'h00000077;
    bus_if.wstrb   = 4'hF;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    cyc1();
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    model_write(BASE + 32'h50, 32'h00000077, 4'hF);
    bus_if.araddr  = BASE + 32'h10;
    bus_if.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid",  32'(bus_if.bvalid),  32'd1);
      chk("stall_awready", 32'(bus_if.awready), 32'd0);
      chk("stall_wready",  32'(bus_if.wready),  32'd0);
      if (i == 1) begin
        chk("stall_rvalid", 32'(bus_if.rvalid), 32'd1);
        chk("stall_rdata",  bus_if.rdata, 32'hDEADBEEF);
        bus_if.rready = 1'b1;
      end
      if (i == 2) chk("stall_r_done", 32'(bus_if.rvalid), 32'd0);
      cyc1();
      if (i == 0) bus_if.arvalid = 1'b0;
      if (i == 1) bus_if.rready = 1'b0;
    end
    bus_if.bready = 1'b1;
    cyc1();
    bus_if.bready = 1'b0;
    chk("stall_b_done", 32'(bus_if.bvalid), 32'd0);
    rd(BASE + 32'h50);

    // Read and write of one word handshaken on the same edge.
    wr(BASE + 32'h20, 32'h1, 4'hF, 0, 0);
    bus_if.awaddr  = BASE + 32'h20;
    bus_if.araddr  = BASE + 32'h20;
    bus_if.wdata   = 32'h2;
    bus_if.wstrb   = 4'hF;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    bus_if.arvalid = 1'b1;
    cyc1();
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    bus_if.arvalid = 1'b0;
    chk("same_edge_bvalid", 32'(bus_if.bvalid), 32'd1);
    chk("same_edge_rvalid", 32'(bus_if.rvalid), 32'd1);
    chk("same_edge_old",    bus_if.rdata, 32'h1);
    bus_if.bready = 1'b1;
    bus_if.rready = 1'b1;
    cyc1();
    bus_if.bready = 1'b0;
    bus_if.rready = 1'b0;
    model_write(BASE + 32'h20, 32'h2, 4'hF);
    rd(BASE + 32'h20);

    // One past the top of the window.
    wr(BASE, 32'h0BADF00D, 4'hF, 0, 0);
    wr(BASE + SIZE, 32'h12345678, 4'hF, 0, 0);
    rd(BASE + SIZE);
    rd(BASE);

    // Reset while a write address is held and an R beat is pending.
    wr(BASE + 32'h4, 32'h55, 4'hF, 0, 0);
    bus_if.awaddr  = BASE + 32'h4;
    bus_if.awvalid = 1'b1;
    bus_if.araddr  = BASE + 32'h4;
    bus_if.arvalid = 1'b1;
    cyc1();
    bus_if.awvalid = 1'b0;
    bus_if.arvalid = 1'b0;
    chk("waddr_awready", 32'(bus_if.awready), 32'd0);
    chk("waddr_rvalid",  32'(bus_if.rvalid),  32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_awready", 32'(bus_if.awready), 32'd1);
    chk("async_rvalid",  32'(bus_if.rvalid),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_if.wdata  = 32'hFFFFFFFF;
    bus_if.wstrb  = 4'hF;
    cyc1();
    chk("post_rst_bvalid", 32'(bus_if.bvalid), 32'd0);
    chk("post_rst_wready", 32'(bus_if.wready), 32'd1);
    rd(BASE + 32'h4);
    wr(BASE + 32'h4, 32'h66, 4'hF, -1, 1);
    rd(BASE + 32'h4);

    for (int w = 0; w < 16; w++) wr(BASE + 32'h100 + 32'(w * 4), $urandom, 4'hF, 0, 0);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = BASE + 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        wr(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
           int'($urandom_range(0, 2)));
      else
        rd(a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
